// File: rtl/mmio_io_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_io_ctrl
//
// Memory-mapped I/O block that sits on the CPU data bus next to RAM.
// It provides three resources:
//   * NUM_OUT writable output registers (e.g. LEDs).
//   * NUM_IN input ports. Each port passes through a 2-flop synchroniser.
//   * A free-running DATA_W-bit cycle timer. It has a compare register and
//     sticky status flags (MATCH, CHANGE, OVF). The flags clear when
//     STATUS is read.
//
// Register map (offsets from each base address):
//   BASE_OUT + i : OUT[i]  read/write, OUT_W bits, zero-extended on read
//   BASE_IN  + i : IN[i]   read-only, synchronised input, sign- or
//                          zero-extended depending on SIGN_EXT
//   BASE_TMR + 0 : COUNT   read/write
//   BASE_TMR + 1 : CMP     read/write
//   BASE_TMR + 2 : STATUS  bit0 MATCH, bit1 CHANGE, bit2 OVF; clear-on-read
//
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   m_cmd      : bus command, 2'b01 read, 2'b10 write, others idle
//   m_addr     : bus address
//   write_data : bus write data
//   read_data  : combinational read data, 0 unless read_valid
//   read_valid : current access is a read of a mapped address
//   sw_in      : asynchronous input ports, port i at [i*IN_W +: IN_W]
//   led_out    : output registers, register i at [i*OUT_W +: OUT_W]
//   irq        : OR of all STATUS flags
// ---------------------------------------------------------------------------
module mmio_io_ctrl #(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 16,
    parameter int                NUM_OUT  = 2,
    parameter int                NUM_IN   = 2,
    parameter int                OUT_W    = 8,
    parameter int                IN_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_OUT = 9'h100,
    parameter logic [ADDR_W-1:0] BASE_IN  = 9'h140,
    parameter logic [ADDR_W-1:0] BASE_TMR = 9'h180,
    parameter bit                SIGN_EXT = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                m_cmd,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic [DATA_W-1:0]         write_data,
    output logic [DATA_W-1:0]         read_data,
    output logic                      read_valid,
    input  logic [NUM_IN*IN_W-1:0]    sw_in,
    output logic [NUM_OUT*OUT_W-1:0]  led_out,
    output logic                      irq
);

    localparam logic [1:0] CMD_RD = 2'b01;
    localparam logic [1:0] CMD_WR = 2'b10;

    localparam logic [ADDR_W-1:0] ADDR_COUNT  = BASE_TMR;
    localparam logic [ADDR_W-1:0] ADDR_CMP    = BASE_TMR + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = BASE_TMR + ADDR_W'(2);

    localparam int ST_MATCH  = 0;
    localparam int ST_CHANGE = 1;
    localparam int ST_OVF    = 2;

    // ------------------------------------------------------------------
    // Bus command decode
    // ------------------------------------------------------------------
    logic rd_en;
    logic wr_en;

    assign rd_en = (m_cmd == CMD_RD);
    assign wr_en = (m_cmd == CMD_WR);

    logic hit_count;
    logic hit_cmp;
    logic hit_status;

    assign hit_count  = (m_addr == ADDR_COUNT);
    assign hit_cmp    = (m_addr == ADDR_CMP);
    assign hit_status = (m_addr == ADDR_STATUS);

    // ------------------------------------------------------------------
    // Output registers
    // Each register decodes its own address. Its read data is folded into
    // a per-register OR chain, so the read mux needs no variable indexing.
    // ------------------------------------------------------------------
    logic [NUM_OUT-1:0] out_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
            localparam logic [ADDR_W-1:0] ADDR_I = BASE_OUT + ADDR_W'(gi);

            logic [OUT_W-1:0]  led_reg;
            logic [DATA_W-1:0] sel;
            logic [DATA_W-1:0] acc;

            assign out_hit[gi] = (m_addr == ADDR_I);

            always_ff @(posedge clk) begin
                if (reset) begin
                    led_reg <= '0;
                end else if (wr_en && out_hit[gi]) begin
                    led_reg <= write_data[OUT_W-1:0];
                end
            end

            assign led_out[gi*OUT_W +: OUT_W] = led_reg;
            assign sel = out_hit[gi] ? DATA_W'(led_reg) : '0;

            if (gi == 0) begin : g_first
                assign acc = sel;
            end else begin : g_chain
                assign acc = g_out[gi-1].acc | sel;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input synchronisers
    // sync1/sync2 form the 2-flop synchroniser. prev_reg holds sync2 from
    // the previous cycle and is used for change detection.
    // ------------------------------------------------------------------
    logic [NUM_IN*IN_W-1:0] sync1_reg;
    logic [NUM_IN*IN_W-1:0] sync2_reg;
    logic [NUM_IN*IN_W-1:0] prev_reg;
    logic [1:0]             warm_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
            warm_reg  <= '0;
        end else begin
            sync1_reg <= sw_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            // Saturates at 3. Until then, the synchroniser is still filling
            // from its reset zeros, so apparent changes are not real.
            if (warm_reg != 2'd3) begin
                warm_reg <= warm_reg + 2'd1;
            end
        end
    end

    logic [NUM_IN-1:0] in_hit;

    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_in
            localparam logic [ADDR_W-1:0] ADDR_I = BASE_IN + ADDR_W'(gi);

            logic [IN_W-1:0]   port_val;
            logic [DATA_W-1:0] port_ext;
            logic [DATA_W-1:0] sel;
            logic [DATA_W-1:0] acc;

            assign in_hit[gi] = (m_addr == ADDR_I);
            assign port_val   = sync2_reg[gi*IN_W +: IN_W];

            if (SIGN_EXT) begin : g_sext
                assign port_ext = DATA_W'($signed(port_val));
            end else begin : g_zext
                assign port_ext = DATA_W'(port_val);
            end

            assign sel = in_hit[gi] ? port_ext : '0;

            if (gi == 0) begin : g_first
                assign acc = sel;
            end else begin : g_chain
                assign acc = g_in[gi-1].acc | sel;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Timer, compare and status flags
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] count_reg;
    logic [DATA_W-1:0] cmp_reg;
    logic [2:0]        status_reg;
    logic [2:0]        status_next;

    logic count_wr;
    logic cmp_wr;
    logic status_clr;
    logic match_set;
    logic change_set;
    logic ovf_set;

    assign count_wr   = wr_en && hit_count;
    assign cmp_wr     = wr_en && hit_cmp;
    assign status_clr = rd_en && hit_status;

    // The comparison uses the registered COUNT. A value written last cycle
    // is therefore compared exactly like one reached by counting.
    assign match_set  = (count_reg == cmp_reg);
    // A COUNT write replaces the increment, so it can never cause a wrap.
    assign ovf_set    = !count_wr && (count_reg == {DATA_W{1'b1}});
    assign change_set = (warm_reg == 2'd3) && (sync2_reg != prev_reg);

    always_comb begin
        status_next = status_clr ? 3'b000 : status_reg;
        // Set conditions are applied after the clear, so a flag set in the
        // same cycle as a clearing read stays set.
        status_next[ST_MATCH]  = status_next[ST_MATCH]  | match_set;
        status_next[ST_CHANGE] = status_next[ST_CHANGE] | change_set;
        status_next[ST_OVF]    = status_next[ST_OVF]    | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg  <= '0;
            cmp_reg    <= '1;
            status_reg <= '0;
        end else begin
            if (count_wr) begin
                count_reg <= write_data;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
            if (cmp_wr) begin
                cmp_reg <= write_data;
            end
            status_reg <= status_next;
        end
    end

    assign irq = |status_reg;

    // ------------------------------------------------------------------
    // Read path (combinational)
    // The decodes are mutually exclusive for a sane address map, so the
    // read mux can be a plain OR of the gated sources.
    // ------------------------------------------------------------------
    logic              mapped;
    logic [DATA_W-1:0] tmr_data;
    logic [DATA_W-1:0] mux_data;

    assign mapped = (|out_hit) | (|in_hit) | hit_count | hit_cmp | hit_status;

    assign tmr_data = (hit_count  ? count_reg           : '0)
                    | (hit_cmp    ? cmp_reg             : '0)
                    | (hit_status ? DATA_W'(status_reg) : '0);

    assign mux_data = g_out[NUM_OUT-1].acc | g_in[NUM_IN-1].acc | tmr_data;

    assign read_valid = rd_en && mapped;
    assign read_data  = read_valid ? mux_data : '0;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mmio_io_ctrl
//
// Directed steps followed by a randomised phase. Every cycle's outputs are
// compared with a transaction-level reference model of the register map.
// The model tracks the timer as plain modular arithmetic. It models the
// input path as "the value sampled two edges ago".
// ---------------------------------------------------------------------------
module tb_mmio_io_ctrl;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] RD  = 2'b01;
    localparam logic [1:0] WR  = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_cmd;
    logic [8:0]  m_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        read_valid;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        irq;

    always #5 clk = ~clk;

    mmio_io_ctrl #(
        .ADDR_W   (9),
        .DATA_W   (16),
        .NUM_OUT  (2),
        .NUM_IN   (2),
        .OUT_W    (8),
        .IN_W     (8),
        .BASE_OUT (9'h100),
        .BASE_IN  (9'h140),
        .BASE_TMR (9'h180),
        .SIGN_EXT (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m_cmd      (m_cmd),
        .m_addr     (m_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .read_valid (read_valid),
        .sw_in      (sw_in),
        .led_out    (led_out),
        .irq        (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Value applied to sw_in in the middle of the next cycle.
    logic [15:0] sw_next = 16'h0000;

    // Reference model state
    logic [7:0]  m_led0, m_led1;
    logic [15:0] m_count, m_cmp;
    logic        m_match, m_change, m_ovf;
    logic [15:0] seen0, seen1, seen2;  // sw_in at the last three edges, newest first
    int          edges_out_of_reset;
    bit          model_valid = 1'b0;

    // Outputs observed during the most recent cycle
    logic        obs_valid;
    logic [15:0] obs_data;
    logic        obs_irq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] port_value(input bit hi);
        logic [7:0] b;
        b = hi ? seen1[15:8] : seen1[7:0];
        return {{8{b[7]}}, b};
    endfunction

    task automatic model_read(input logic [1:0] cmd, input logic [8:0] addr,
                              output logic v, output logic [15:0] d);
        v = 1'b0;
        d = 16'h0000;
        if (cmd == RD) begin
            v = 1'b1;
            case (addr)
                9'h100:  d = {8'h00, m_led0};
                9'h101:  d = {8'h00, m_led1};
                9'h140:  d = port_value(1'b0);
                9'h141:  d = port_value(1'b1);
                9'h180:  d = m_count;
                9'h181:  d = m_cmp;
                9'h182:  d = {13'd0, m_ovf, m_change, m_match};
                default: v = 1'b0;
            endcase
        end
    endtask

    task automatic model_edge(input logic rst, input logic [1:0] cmd, input logic [8:0] addr,
                              input logic [15:0] wd, input logic [15:0] sw);
        logic set_m, set_c, set_o, cnt_wr;
        if (rst) begin
            m_led0 = 8'h00; m_led1 = 8'h00;
            m_count = 16'h0000; m_cmp = 16'hFFFF;
            m_match = 1'b0; m_change = 1'b0; m_ovf = 1'b0;
            seen0 = 16'h0000; seen1 = 16'h0000; seen2 = 16'h0000;
            edges_out_of_reset = 0;
            model_valid = 1'b1;
        end else begin
            cnt_wr = (cmd == WR) && (addr == 9'h180);
            set_m  = (m_count == m_cmp);
            set_o  = !cnt_wr && (m_count == 16'hFFFF);
            set_c  = (edges_out_of_reset >= 3) && (seen1 != seen2);
            if ((cmd == RD) && (addr == 9'h182)) begin
                m_match = 1'b0; m_change = 1'b0; m_ovf = 1'b0;
            end
            m_match  = m_match  | set_m;
            m_change = m_change | set_c;
            m_ovf    = m_ovf    | set_o;
            m_count  = m_count + 16'd1;
            if (cmd == WR) begin
                case (addr)
                    9'h100:  m_led0  = wd[7:0];
                    9'h101:  m_led1  = wd[7:0];
                    9'h180:  m_count = wd;
                    9'h181:  m_cmp   = wd;
                    default: ;
                endcase
            end
            seen2 = seen1; seen1 = seen0; seen0 = sw;
            if (edges_out_of_reset < 3) edges_out_of_reset++;
        end
    endtask

    // One bus cycle. The task is entered 1 time unit after a rising edge.
    // sw_in changes mid-cycle. Outputs are sampled on the falling edge.
    // The task then waits for the next rising edge and steps the model.
    task automatic cycle(input logic rst, input logic [1:0] cmd, input logic [8:0] addr,
                         input logic [15:0] wd);
        logic        ev;
        logic [15:0] ed;
        reset = rst; m_cmd = cmd; m_addr = addr; write_data = wd;
        #3;
        sw_in = sw_next;
        #1;
        obs_valid = read_valid; obs_data = read_data; obs_irq = irq;
        if (model_valid) begin
            model_read(cmd, addr, ev, ed);
            check("read_valid", {31'd0, obs_valid}, {31'd0, ev});
            check("read_data", {16'd0, obs_data}, {16'd0, ed});
            check("irq", {31'd0, obs_irq}, {31'd0, (m_match | m_change | m_ovf)});
            check("led_out", {16'd0, led_out}, {16'd0, m_led1, m_led0});
        end
        model_edge(rst, cmd, addr, wd, sw_in);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          seen;
        logic [1:0]  rcmd;
        logic [8:0]  raddr;
        logic [15:0] rwd;
        logic        rrst;

        reset = 1'b1; m_cmd = NOP; m_addr = '0; write_data = '0; sw_in = '0;
        @(posedge clk);
        #1;

        // Reset state
        cycle(1'b1, NOP, 9'h000, 16'h0);
        cycle(1'b1, NOP, 9'h000, 16'h0);
        cycle(1'b0, RD, 9'h182, 16'h0);
        check("rst_status", {16'd0, obs_data}, 32'h0000);
        check("rst_irq", {31'd0, obs_irq}, 32'd0);
        check("rst_led", {16'd0, led_out}, 32'h0000);
        cycle(1'b0, RD, 9'h181, 16'h0);
        check("rst_cmp", {16'd0, obs_data}, 32'hFFFF);
        cycle(1'b0, RD, 9'h180, 16'h0);
        check("rst_count", {16'd0, obs_data}, 32'h0002);

        // Output registers
        cycle(1'b0, WR, 9'h100, 16'h00A5);
        cycle(1'b0, WR, 9'h101, 16'h1234);
        cycle(1'b0, RD, 9'h101, 16'h0);
        check("t1_rdata", {16'd0, obs_data}, 32'h0034);
        check("t1_rvalid", {31'd0, obs_valid}, 32'd1);
        check("t1_led", {16'd0, led_out}, 32'h34A5);

        // Input port with sign extension, then an unmapped read
        sw_next = 16'h0085;
        repeat (3) cycle(1'b0, NOP, 9'h000, 16'h0);
        cycle(1'b0, RD, 9'h140, 16'h0);
        check("t2_in0", {16'd0, obs_data}, 32'hFF85);
        cycle(1'b0, RD, 9'h1F0, 16'h0);
        check("t2_unmapped_valid", {31'd0, obs_valid}, 32'd0);
        check("t2_unmapped_data", {16'd0, obs_data}, 32'h0000);

        // MATCH and clear-on-read
        repeat (2) cycle(1'b0, NOP, 9'h000, 16'h0);
        cycle(1'b0, RD, 9'h182, 16'h0);
        cycle(1'b0, WR, 9'h180, 16'h0010);
        cycle(1'b0, WR, 9'h181, 16'h0014);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            cycle(1'b0, NOP, 9'h000, 16'h0);
            if (obs_irq) seen = 1'b1;
        end
        check("t3_irq_within_6", {31'd0, seen}, 32'd1);
        cycle(1'b0, RD, 9'h182, 16'h0);
        check("t3_status_match", {16'd0, obs_data}, 32'h0001);
        cycle(1'b0, RD, 9'h182, 16'h0);
        check("t3_status_cleared", {16'd0, obs_data}, 32'h0000);

        // OVF set in the same cycle as a clearing read
        cycle(1'b0, WR, 9'h180, 16'hFFFE);
        cycle(1'b0, NOP, 9'h000, 16'h0);
        cycle(1'b0, RD, 9'h182, 16'h0);
        check("t4_status_before", {16'd0, obs_data}, 32'h0000);
        cycle(1'b0, NOP, 9'h000, 16'h0);
        check("t4_irq", {31'd0, obs_irq}, 32'd1);
        cycle(1'b0, RD, 9'h182, 16'h0);
        check("t4_ovf_kept", {16'd0, obs_data}, 32'h0004);

        // CHANGE latency from a mid-cycle input edge
        cycle(1'b0, WR, 9'h181, 16'h8000);
        cycle(1'b0, WR, 9'h180, 16'h0000);
        cycle(1'b0, RD, 9'h182, 16'h0);
        sw_next = sw_next ^ 16'h0100;
        cycle(1'b0, NOP, 9'h000, 16'h0);
        cycle(1'b0, NOP, 9'h000, 16'h0);
        check("t5_after_edge1", {31'd0, obs_irq}, 32'd0);
        cycle(1'b0, NOP, 9'h000, 16'h0);
        check("t5_after_edge2", {31'd0, obs_irq}, 32'd0);
        cycle(1'b0, NOP, 9'h000, 16'h0);
        check("t5_after_edge3", {31'd0, obs_irq}, 32'd1);
        cycle(1'b0, RD, 9'h182, 16'h0);
        check("t5_status_change", {16'd0, obs_data}, 32'h0002);

        // Non-zero inputs held through reset do not raise CHANGE
        sw_next = 16'h5A3C;
        cycle(1'b1, NOP, 9'h000, 16'h0);
        cycle(1'b1, NOP, 9'h000, 16'h0);
        repeat (6) begin
            cycle(1'b0, NOP, 9'h000, 16'h0);
            check("t5_warmup_irq", {31'd0, obs_irq}, 32'd0);
        end
        cycle(1'b0, RD, 9'h182, 16'h0);
        check("t5_warmup_status", {16'd0, obs_data}, 32'h0000);

        // Reset wins over a concurrent write
        cycle(1'b0, WR, 9'h100, 16'h00C3);
        cycle(1'b1, WR, 9'h100, 16'hFFFF);
        check("t6_led", {16'd0, led_out}, 32'h0000);
        cycle(1'b0, RD, 9'h180, 16'h0);
        check("t6_count", {16'd0, obs_data}, 32'h0000);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 11))
                0:       raddr = 9'h100;
                1:       raddr = 9'h101;
                2:       raddr = 9'h102;
                3:       raddr = 9'h140;
                4:       raddr = 9'h141;
                5:       raddr = 9'h142;
                6, 7:    raddr = 9'h180;
                8:       raddr = 9'h181;
                9, 10:   raddr = 9'h182;
                default: raddr = 9'($urandom);
            endcase
            rcmd = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       rwd = m_cmp - 16'($urandom_range(0, 3));
                1:       rwd = 16'hFFFF - 16'($urandom_range(0, 3));
                default: rwd = 16'($urandom);
            endcase
            rrst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) sw_next = 16'($urandom);
            cycle(rrst, rcmd, raddr, rwd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
Memory-mapped I/O controller on the CPU data bus, alongside RAM. It decodes `m_cmd` and `m_addr`, and provides three things: NUM_OUT writable output registers (LEDs), NUM_IN synchronised input ports (switches), and a DATA_W-bit cycle timer with compare and sticky status flags. It drives `read_data` plus a `read_valid` enable, which top level uses to gate the shared read bus.

Parameters:
- ADDR_W, 9: width of `m_addr`.
- DATA_W, 16: bus width; also the width of the timer and compare registers.
- NUM_OUT, 2: number of output registers (1..64).
- NUM_IN, 2: number of input ports (1..64).
- OUT_W, 8: bits per output register (≤ DATA_W).
- IN_W, 8: bits per input port (≤ DATA_W).
- BASE_OUT, 9'h100: address of output register 0.
- BASE_IN, 9'h140: address of input port 0.
- BASE_TMR, 9'h180: address of the timer register block.
- SIGN_EXT, 1: 1 = inputs are sign-extended to DATA_W on read; 0 = zero-extended.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- m_cmd, in, 2: bus command; 2'b01 = read, 2'b10 = write, others = none.
- m_addr, in, ADDR_W: bus address.
- write_data, in, DATA_W: write data.
- read_data, out, DATA_W: read data; 0 when `read_valid` = 0.
- read_valid, out, 1: high when the current access is a read of a mapped address.
- sw_in, in, NUM_IN*IN_W: asynchronous inputs; port i is bits [i*IN_W +: IN_W].
- led_out, out, NUM_OUT*OUT_W: output registers, concatenated the same way as `sw_in`.
- irq, out, 1: OR of all STATUS bits.

Behaviour:
- Clocking and reset:
  - One clock (`clk`); reset is synchronous and active-high (`reset`).
  - Reset values: `led_out` = 0, COUNT = 0, CMP = all ones, STATUS = 0, synchroniser and previous-sample flops = 0, warm-up counter = 0, `irq` = 0.
  - `read_data` and `read_valid` are combinational, so they read 0 during reset unless a read is in progress.
- Address map (offsets from each base):
  - OUT[i] at BASE_OUT+i: read/write. A write loads `write_data[OUT_W-1:0]`. A read returns the value zero-extended.
  - IN[i] at BASE_IN+i: read-only. Returns the 2-flop-synchronised `sw_in` port i, extended according to SIGN_EXT.
  - COUNT at BASE_TMR+0: read/write.
  - CMP at BASE_TMR+1: read/write.
  - STATUS at BASE_TMR+2: bit0 = MATCH, bit1 = CHANGE, bit2 = OVF, remaining bits read 0.
- Bus rules:
  - Reads are combinational in the same cycle; writes take effect at the next rising edge, so a read in the following cycle sees the new value.
  - Writes to IN or STATUS are ignored.
  - Unmapped addresses: `read_valid` = 0, `read_data` = 0, writes have no effect.
  - `m_cmd` of 2'b00 or 2'b11 is a no-op.
- Timer:
  - COUNT increments by 1 every cycle, wrapping from all-ones to 0.
  - At the edge where COUNT wraps to 0, OVF is set.
  - A write to COUNT loads `write_data` and suppresses that cycle's increment; no OVF is generated by the write itself.
- MATCH: set at the edge following any cycle in which COUNT == CMP, including a COUNT just written.
- CHANGE:
  - Set at an edge where the synchronised value of any input port differs from its previous-cycle sample.
  - Suppressed for the first 3 cycles after reset deasserts (2-bit warm-up counter) to mask synchroniser fill.
- STATUS clear-on-read:
  - A read of STATUS (m_cmd = 01) returns the current flags and clears all bits at the next edge.
  - If a flag's set condition occurs in the same cycle as the clearing read, set wins: the flag stays 1.
- `irq` is combinational: `irq` = |STATUS[2:0].
- Reset mid-operation: reset takes priority over any concurrent write or flag set.

Test Plan:
1. Reset, then write 16'h00A5 to 9'h100 and 16'h1234 to 9'h101 → `led_out[7:0]` = 8'hA5, `led_out[15:8]` = 8'h34; a read of 9'h101 returns 16'h0034 with `read_valid` = 1.
2. `sw_in[7:0]` = 8'h85, wait 3 cycles, read 9'h140 → 16'hFF85 (SIGN_EXT = 1); a read of 9'h1F0 → `read_valid` = 0, `read_data` = 0.
3. Write COUNT = 16'h0010 and CMP = 16'h0014 → MATCH = 1 and `irq` = 1 within 6 cycles; a STATUS read returns 16'h0001, and the next STATUS read returns 16'h0000.
4. Write COUNT = 16'hFFFE → OVF sets 2 cycles later; issue a STATUS read on the exact cycle OVF sets → OVF remains 1 afterwards.
5. Toggle `sw_in[8]` with the asynchronous edge placed mid-cycle → CHANGE = 1 exactly 3 edges later. Set `sw_in` ≠ 0 through reset → CHANGE remains 0 after reset deasserts.
6. Assert `reset` in the same cycle as a write of 16'hFFFF to 9'h100 → `led_out` = 0 and COUNT = 0 after the edge.
